// File: rtl/pito_pkg.sv
// rtl/pito_pkg.sv - shared types and constants for the pito host loader
package pito_pkg;

  localparam int PITO_IMEM_AW = 12;
  localparam int PITO_DMEM_AW = 12;

  localparam logic [7:0] LOADER_ACK = 8'hA5;
  localparam logic [7:0] LOADER_NAK = 8'h5A;

  typedef enum logic [7:0] {
    CMD_WR_IMEM = 8'h01,
    CMD_WR_DMEM = 8'h02,
    CMD_RD_IMEM = 8'h03,
    CMD_RD_DMEM = 8'h04,
    CMD_HOLD    = 8'h10,
    CMD_RELEASE = 8'h11
  } host_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CHECK,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_TX_LOAD,
    ST_TX_STROBE,
    ST_TX_GUARD,
    ST_TX_WAIT
  } loader_state_e;

  function automatic logic cmd_is_mem(input logic [7:0] c);
    return (c == CMD_WR_IMEM) || (c == CMD_WR_DMEM) ||
           (c == CMD_RD_IMEM) || (c == CMD_RD_DMEM);
  endfunction

endpackage

// File: rtl/pito_host_tx_seq.sv
// rtl/pito_host_tx_seq.sv - serializes a 1- or 4-byte reply onto the uart transmitter
module pito_host_tx_seq
  import pito_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] word_i,
  input  logic        four_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_o,
  output logic        done_o
);

  loader_state_e state_q, state_d;
  logic [31:0]   shift_q;
  logic [1:0]    left_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The guard cycle gives the uart one clock to raise busy after a strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_i) state_d = ST_TX_STROBE;
      ST_TX_STROBE: if (!tx_busy_i) state_d = ST_TX_GUARD;
      ST_TX_GUARD:  state_d = ST_TX_WAIT;
      ST_TX_WAIT:   if (!tx_busy_i) state_d = (left_q == 2'd0) ? ST_IDLE : ST_TX_STROBE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_wr_o   = (state_q == ST_TX_STROBE) && !tx_busy_i;
    done_o    = (state_q == ST_TX_WAIT) && !tx_busy_i && (left_q == 2'd0);
    tx_data_o = shift_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 32'd0;
      left_q  <= 2'd0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        shift_q <= word_i;
        left_q  <= four_i ? 2'd3 : 2'd0;
      end else if (tx_wr_o) begin
        shift_q <= {8'd0, shift_q[31:8]};
      end
      if (state_q == ST_TX_WAIT && !tx_busy_i && left_q != 2'd0)
        left_q <= left_q - 2'd1;
    end
  end

endmodule

// File: rtl/pito_host_loader.sv
// rtl/pito_host_loader.sv - uart framed-command bridge onto the pito imem/dmem external ports
module pito_host_loader
  import pito_pkg::*;
#(
  parameter int         IMEM_AW        = PITO_IMEM_AW,
  parameter int         DMEM_AW        = PITO_DMEM_AW,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = LOADER_ACK,
  parameter logic [7:0] NAK_BYTE       = LOADER_NAK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_wr_o,
  input  logic               tx_busy_i,
  output logic               imem_req_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  output logic [3:0]         imem_be_o,
  input  logic [31:0]        imem_rdata_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [31:0]        dmem_wdata_o,
  output logic [3:0]         dmem_be_o,
  input  logic [31:0]        dmem_rdata_i,
  output logic               core_hold_o,
  output logic               busy_o
);

  loader_state_e state_q, state_d;
  logic [7:0]    cmd_q;
  logic [31:0]   addr_q, data_q, reply_q, idle_cnt_q;
  logic [1:0]    byte_cnt_q;
  logic          reply_four_q, hold_q;
  logic          cmd_write, cmd_imem, in_range, timeout_hit, tx_start, tx_done;

  always_comb begin
    cmd_write   = (cmd_q == CMD_WR_IMEM) || (cmd_q == CMD_WR_DMEM);
    cmd_imem    = (cmd_q == CMD_WR_IMEM) || (cmd_q == CMD_RD_IMEM);
    in_range    = cmd_imem ? ((addr_q >> IMEM_AW) == 32'd0) : ((addr_q >> DMEM_AW) == 32'd0);
    timeout_hit = (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // A byte that arrives on the same clock as the timeout still belongs to the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (rx_valid_i) state_d = cmd_is_mem(rx_data_i) ? ST_ADDR : ST_TX_LOAD;
      ST_ADDR:
        if (rx_valid_i) begin
          if (byte_cnt_q == 2'd3) state_d = cmd_write ? ST_DATA : ST_CHECK;
        end else if (timeout_hit) state_d = ST_IDLE;
      ST_DATA:
        if (rx_valid_i) begin
          if (byte_cnt_q == 2'd3) state_d = ST_CHECK;
        end else if (timeout_hit) state_d = ST_IDLE;
      ST_CHECK:    state_d = in_range ? ST_MEM_REQ : ST_TX_LOAD;
      ST_MEM_REQ:  state_d = cmd_write ? ST_TX_LOAD : ST_MEM_WAIT;
      ST_MEM_WAIT: state_d = ST_TX_LOAD;
      ST_TX_LOAD:  state_d = ST_TX_WAIT;
      ST_TX_WAIT:  if (tx_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o   = (state_q == ST_MEM_REQ) && cmd_imem;
    dmem_req_o   = (state_q == ST_MEM_REQ) && !cmd_imem;
    imem_we_o    = imem_req_o && cmd_write;
    dmem_we_o    = dmem_req_o && cmd_write;
    imem_be_o    = imem_req_o ? 4'hF : 4'h0;
    dmem_be_o    = dmem_req_o ? 4'hF : 4'h0;
    imem_addr_o  = imem_req_o ? addr_q[IMEM_AW-1:0] : '0;
    dmem_addr_o  = dmem_req_o ? addr_q[DMEM_AW-1:0] : '0;
    imem_wdata_o = imem_we_o ? data_q : 32'd0;
    dmem_wdata_o = dmem_we_o ? data_q : 32'd0;
    tx_start     = (state_q == ST_TX_LOAD);
    busy_o       = (state_q != ST_IDLE);
    core_hold_o  = hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= 8'd0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      reply_q      <= 32'd0;
      reply_four_q <= 1'b0;
      byte_cnt_q   <= 2'd0;
      idle_cnt_q   <= 32'd0;
      hold_q       <= 1'b1;
    end else begin
      if (rx_valid_i || timeout_hit || !(state_q == ST_ADDR || state_q == ST_DATA))
        idle_cnt_q <= 32'd0;
      else
        idle_cnt_q <= idle_cnt_q + 32'd1;

      case (state_q)
        ST_IDLE:
          if (rx_valid_i) begin
            cmd_q        <= rx_data_i;
            byte_cnt_q   <= 2'd0;
            reply_four_q <= 1'b0;
            reply_q      <= {24'd0, (cmd_is_mem(rx_data_i) || rx_data_i == CMD_HOLD ||
                                     rx_data_i == CMD_RELEASE) ? ACK_BYTE : NAK_BYTE};
            if (rx_data_i == CMD_HOLD)    hold_q <= 1'b1;
            if (rx_data_i == CMD_RELEASE) hold_q <= 1'b0;
          end
        ST_ADDR:
          if (rx_valid_i) begin
            addr_q     <= {rx_data_i, addr_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        ST_DATA:
          if (rx_valid_i) begin
            data_q     <= {rx_data_i, data_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        ST_CHECK:
          if (!in_range) reply_q <= {24'd0, NAK_BYTE};
        ST_MEM_WAIT: begin
          reply_q      <= cmd_imem ? imem_rdata_i : dmem_rdata_i;
          reply_four_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  pito_host_tx_seq u_tx_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (tx_start),
    .word_i    (reply_q),
    .four_i    (reply_four_q),
    .tx_busy_i (tx_busy_i),
    .tx_data_o (tx_data_o),
    .tx_wr_o   (tx_wr_o),
    .done_o    (tx_done)
  );

endmodule

// File: tb/tb_pito_host_loader.sv
// tb/tb_pito_host_loader.sv - randomized self-checking bench for pito_host_loader
module tb_pito_host_loader;

  localparam int IAW = 8;
  localparam int DAW = 6;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     rx_data = 8'd0;
  logic           rx_valid = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_wr;
  logic           tx_busy = 1'b0;
  logic           imem_req, imem_we, dmem_req, dmem_we;
  logic [IAW-1:0] imem_addr;
  logic [DAW-1:0] dmem_addr;
  logic [31:0]    imem_wdata, dmem_wdata;
  logic [31:0]    imem_rdata = 32'd0, dmem_rdata = 32'd0;
  logic [3:0]     imem_be, dmem_be;
  logic           core_hold, busy;

  pito_host_loader #(.IMEM_AW(IAW), .DMEM_AW(DAW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_wr_o(tx_wr), .tx_busy_i(tx_busy),
    .imem_req_o(imem_req), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .imem_be_o(imem_be), .imem_rdata_i(imem_rdata),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be), .dmem_rdata_i(dmem_rdata),
    .core_hold_o(core_hold), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dmem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
  } acc_t;

  acc_t        acc_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc[$];
  int          checks = 0, errors = 0, cyc = 0, uart_cnt = 0;
  bit          wr_seen = 0, force_busy = 0;

  logic [31:0] sram_i [0:(1<<IAW)-1];
  logic [31:0] sram_d [0:(1<<DAW)-1];
  logic [31:0] mdl_i  [0:(1<<IAW)-1];
  logic [31:0] mdl_d  [0:(1<<DAW)-1];
  bit          mdl_hold = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responder-side SRAMs with one cycle read latency.
  always @(posedge clk) begin
    if (imem_req) begin
      if (imem_we) sram_i[imem_addr] <= imem_wdata;
      else         imem_rdata <= sram_i[imem_addr];
    end
    if (dmem_req) begin
      if (dmem_we) sram_d[dmem_addr] <= dmem_wdata;
      else         dmem_rdata <= sram_d[dmem_addr];
    end
  end

  initial begin
    acc_t a;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_req) begin
        a.dmem = 0; a.we = imem_we; a.addr = 32'(imem_addr); a.wdata = imem_wdata;
        a.be = imem_be; a.cyc = cyc; acc_q.push_back(a);
      end
      if (dmem_req) begin
        a.dmem = 1; a.we = dmem_we; a.addr = 32'(dmem_addr); a.wdata = dmem_wdata;
        a.be = dmem_be; a.cyc = cyc; acc_q.push_back(a);
      end
      if (tx_wr) begin
        tx_q.push_back(tx_data);
        tx_cyc.push_back(cyc);
        wr_seen = 1;
      end
    end
  end

  // Uart busy model: goes busy just after each strobe for a random number of clocks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wr_seen) begin
        uart_cnt = $urandom_range(1, 6);
        wr_seen = 0;
      end else if (uart_cnt > 0) uart_cnt--;
      tx_busy = force_busy || (uart_cnt != 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #2;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    acc_q.delete(); tx_q.delete(); tx_cyc.delete();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd,
                           input logic [31:0] addr, input logic [31:0] data);
    logic [7:0]  exp_tx[$];
    bit          is_mem, dm, wr, acc_exp;
    logic [31:0] w;
    clear_mon();
    is_mem = (cmd >= 8'h01 && cmd <= 8'h04);
    dm = (cmd == 8'h02 || cmd == 8'h04);
    wr = (cmd == 8'h01 || cmd == 8'h02);
    acc_exp = 0;
    send_byte(cmd);
    if (is_mem) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (wr) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    end
    wait_idle(tag);

    if (is_mem) begin
      if (addr < (dm ? 32'd1 << DAW : 32'd1 << IAW)) begin
        acc_exp = 1;
        if (wr) begin
          if (dm) mdl_d[addr] = data; else mdl_i[addr] = data;
          exp_tx.push_back(8'hA5);
        end else begin
          w = dm ? mdl_d[addr] : mdl_i[addr];
          for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
        end
      end else exp_tx.push_back(8'h5A);
    end else if (cmd == 8'h10) begin
      mdl_hold = 1; exp_tx.push_back(8'hA5);
    end else if (cmd == 8'h11) begin
      mdl_hold = 0; exp_tx.push_back(8'hA5);
    end else exp_tx.push_back(8'h5A);

    check({tag, "_nacc"}, 32'(acc_q.size()), 32'(acc_exp));
    if (acc_exp && acc_q.size() > 0) begin
      check({tag, "_dmem"}, 32'(acc_q[0].dmem), 32'(dm));
      check({tag, "_we"}, 32'(acc_q[0].we), 32'(wr));
      check({tag, "_addr"}, acc_q[0].addr, addr);
      check({tag, "_be"}, 32'(acc_q[0].be), 32'hF);
      if (wr) check({tag, "_wdata"}, acc_q[0].wdata, data);
      if (wr && tx_cyc.size() > 0) check({tag, "_lat"}, 32'(tx_cyc[0] - acc_q[0].cyc), 32'd2);
    end
    check({tag, "_ntx"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));
    check({tag, "_hold"}, 32'(core_hold), 32'(mdl_hold));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    mdl_hold = 1;
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < (1<<IAW); i++) begin sram_i[i] = 32'd0; mdl_i[i] = 32'd0; end
    for (int i = 0; i < (1<<DAW); i++) begin sram_d[i] = 32'd0; mdl_d[i] = 32'd0; end

    do_reset();
    check("rst_ireq", 32'(imem_req), 32'd0);
    check("rst_dreq", 32'(dmem_req), 32'd0);
    check("rst_txwr", 32'(tx_wr), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_be", 32'({imem_be, dmem_be}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(core_hold), 32'd1);
    rst_n = 1'b1;

    run_frame("wr_imem", 8'h01, 32'h10, 32'hDEADBEEF);
    run_frame("wr_dmem", 8'h02, 32'h4, 32'h12345678);
    run_frame("rd_dmem", 8'h04, 32'h4, 32'd0);
    run_frame("rd_imem", 8'h03, 32'h10, 32'd0);
    run_frame("oor_all1", 8'h02, 32'hFFFF_FFFF, 32'h1);
    run_frame("oor_dmem", 8'h02, 32'd64, 32'h2);
    run_frame("top_imem", 8'h01, 32'd255, 32'hCAFEF00D);
    run_frame("oor_imem", 8'h01, 32'd256, 32'h3);
    run_frame("unk_cmd", 8'h7E, 32'd0, 32'd0);

    clear_mon();
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
    repeat (TMO + 50) @(posedge clk);
    #2;
    check("tmo_nacc", 32'(acc_q.size()), 32'd0);
    check("tmo_ntx", 32'(tx_q.size()), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    run_frame("post_tmo", 8'h01, 32'h20, $urandom);

    run_frame("pre_hold", 8'h02, 32'h5, 32'hA1B2C3D4);
    clear_mon();
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    force_busy = 1;
    send_byte(8'h00);
    repeat (5) @(posedge clk);
    #2;
    send_byte(8'h11); send_byte(8'h01);
    repeat (50) @(posedge clk);
    #2;
    check("bsy_ntx_held", 32'(tx_q.size()), 32'd0);
    force_busy = 0;
    wait_idle("bsy");
    check("bsy_nacc", 32'(acc_q.size()), 32'd1);
    check("bsy_ntx", 32'(tx_q.size()), 32'd4);
    if (tx_q.size() == 4)
      check("bsy_word", {tx_q[3], tx_q[2], tx_q[1], tx_q[0]}, 32'hA1B2C3D4);
    check("bsy_hold", 32'(core_hold), 32'(mdl_hold));

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63));
      case (r)
        0, 1: c = 8'h01;
        2, 3: c = 8'h02;
        4:    c = 8'h03;
        5:    c = 8'h04;
        6:    c = 8'h10;
        7:    c = 8'h11;
        8: begin
          c = 8'($urandom);
          while ((c >= 8'h01 && c <= 8'h04) || c == 8'h10 || c == 8'h11) c = 8'($urandom);
        end
        default: begin
          c = 8'($urandom_range(1, 4));
          a = $urandom | 32'h100;
        end
      endcase
      run_frame($sformatf("rnd%0d", n), c, a, $urandom);
    end

    do_reset();
    check("rst2_hold", 32'(core_hold), 32'd1);
    rst_n = 1'b1;
    run_frame("release", 8'h11, 32'd0, 32'd0);
    run_frame("sethold", 8'h10, 32'd0, 32'd0);
    run_frame("release2", 8'h11, 32'd0, 32'd0);
    clear_mon();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(8'h03 * 8'(i));
    send_byte(8'h55); send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    check("midrst_hold", 32'(core_hold), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    mdl_hold = 1;
    repeat (10) @(posedge clk);
    #2;
    check("midrst_nacc", 32'(acc_q.size()), 32'd0);
    check("midrst_ntx", 32'(tx_q.size()), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    run_frame("post_rst", 8'h03, 32'h10, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pito_host_loader.md
Name: pito_host_loader

Overview:
- UART-driven host bridge that initiates transactions on the pito_soc external memory ports (imem_*_i / dmem_*_i).
- It is the initiator for the responder-side external ports of the instruction and data SRAMs.
- Parses framed byte commands from pito_uart (rx_data/valid) and issues single-word writes or reads. Replies are sent through the pito_uart transmitter (wr/busy).
- Also owns a core-hold output so a program can be loaded before the harts run.

Parameters:
- IMEM_AW, `PITO_INSTR_MEM_ADDR_WIDTH: imem word-address width.
- DMEM_AW, `PITO_DATA_MEM_ADDR_WIDTH: dmem word-address width.
- TIMEOUT_CYCLES, 1000000: maximum idle clocks between bytes of one frame.
- ACK_BYTE, 8'hA5: write/control success reply.
- NAK_BYTE, 8'h5A: error reply.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data_i  in  8  byte from pito_uart rx_data
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- tx_data_o  out  8  byte to pito_uart tx_data
- tx_wr_o  out  1  one-cycle transmit strobe
- tx_busy_i  in  1  pito_uart busy
- imem_req_o, imem_we_o  out  1 each  imem external port request / write enable
- imem_addr_o  out  IMEM_AW  imem word address
- imem_wdata_o  out  32  imem write data
- imem_be_o  out  4  imem byte enables
- imem_rdata_i  in  32  imem read data
- dmem_req_o, dmem_we_o, dmem_addr_o (DMEM_AW), dmem_wdata_o (32), dmem_be_o (4), dmem_rdata_i (32): same as imem, for dmem
- core_hold_o  out  1  1 = keep pito core in reset
- busy_o  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset values: all req/we/tx_wr = 0; addr/wdata/tx_data = 0; be = 4'h0; busy_o = 0; core_hold_o = 1. FSM goes to IDLE. Reset mid-frame discards the frame and issues no memory access.
- Frame format: CMD byte, then ADDR (4 bytes, LSB first, word address), then DATA (4 bytes, LSB first; write commands only).
- CMD 8'h01 = write imem; 8'h02 = write dmem; 8'h03 = read imem; 8'h04 = read dmem.
- CMD 8'h10 = set hold (core_hold_o=1); 8'h11 = release hold (core_hold_o=0). No payload; reply ACK.
- Unknown CMD: reply NAK, return to IDLE.
- FSM states: IDLE, ADDR, DATA, CHECK, MEM_REQ, MEM_WAIT, TX_LOAD, TX_STROBE, TX_GUARD, TX_WAIT.
  - Byte counter: 2 bits, counts 0..3 in ADDR and DATA.
  - IDLE->ADDR on a valid memory CMD; ADDR->DATA (writes) or ->CHECK (reads) after 4th byte; DATA->CHECK after 4th byte.
- Range check (CHECK, one cycle): if addr[31:AW] != 0 for the target memory, reply NAK and issue no access. Otherwise go to MEM_REQ.
- MEM_REQ: exactly one cycle with req=1, be=4'hF, we=1 (write) or 0 (read), addr = addr[AW-1:0]. The other memory's req stays 0.
- Write: after MEM_REQ, reply ACK. Write-to-ACK strobe latency is fixed: tx_wr_o is asserted 2 cycles after req, provided tx_busy_i = 0.
- Read: the SRAM latency is 1. In MEM_WAIT, rdata is captured into a 32-bit shift register. Then 4 bytes are transmitted, LSB first. No ACK follows the data.
- TX handshake:
  - tx_wr_o is pulsed for one cycle only when tx_busy_i = 0.
  - After the pulse, TX_GUARD waits one cycle before sampling busy.
  - TX_WAIT holds until tx_busy_i = 0, then sends the next byte or returns to IDLE.
- Inter-byte timeout: a counter is cleared on each rx_valid_i and counts in ADDR/DATA only. When it reaches TIMEOUT_CYCLES-1, the frame is aborted to IDLE: no reply, no access, counter saturates/clears.
- rx_valid_i arriving while in CHECK/MEM_*/TX_* states: byte dropped (host must wait for the reply). The drop is not an error.
- core_hold_o changes only on 8'h10/8'h11. Memory commands are accepted regardless of hold.

Decomposition:
- Into pito_pkg: the host_cmd_e enum (CMD values), loader_state_e, LOADER_ACK/LOADER_NAK constants.
- Sub-module pito_host_tx_seq: byte serializer. Takes 32-bit word + byte count (1 or 4), drives tx_wr_o/tx_data_o with the guard/busy handshake, and returns done.

Test Plan:
- Reset, then frame 01, 10 00 00 00, EF BE AD DE -> one cycle with imem_req_o=1, we=1, addr=0x10, wdata=0xDEADBEEF, be=F; tx byte A5.
- Frame 02, 04 00 00 00, 78 56 34 12 -> dmem write 0x12345678 @ 0x4. Then frame 04, 04 00 00 00 -> dmem read req at 0x4; tx bytes 78, 56, 34, 12 in order.
- Frame 02 with addr 0xFFFF_FFFF -> no dmem_req_o; tx 5A. Unknown CMD 0x7E -> tx 5A, FSM back to IDLE.
- Send 01 and two address bytes, then idle TIMEOUT_CYCLES (set to 100) -> no req, no tx. A following full valid frame completes normally.
- Hold tx_busy_i=1 for 50 cycles during a read reply -> tx_wr_o stays 0 until busy drops, with exactly 4 strobes total. Extra rx bytes arriving during the reply are ignored.
- Reset -> core_hold_o=1; send 11 -> core_hold_o=0 + A5; send 10 -> core_hold_o=1. Assert rst_n low mid-DATA -> no access, core_hold_o=1.
